// File: rtl/spi_master.sv
// spi_master: sends one 10-bit command frame over SS_n/MOSI and, for read-data commands, captures RX_W MISO bits.
module spi_master #(
    parameter int TURNAROUND = 2,
    parameter int RX_W       = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [9:0]      tx_data,
    output logic            busy,
    output logic            done,
    output logic [RX_W-1:0] rx_data,
    output logic            rx_valid,
    output logic            SS_n,
    output logic            MOSI,
    input  logic            MISO
);
    localparam int M1   = (TURNAROUND > 11) ? TURNAROUND : 11;
    localparam int MAXC = (RX_W > M1) ? RX_W : M1;
    localparam int CW   = $clog2(MAXC);

    typedef enum logic [2:0] {IDLE, SEND, TURN, RECV, END} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [10:0]     sh, sh_n;
    logic            rd, rd_n;
    logic [RX_W-1:0] rx_sh, rx_sh_n, rx_data_n;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sh_n      = sh;
        rd_n      = rd;
        rx_sh_n   = rx_sh;
        rx_data_n = rx_data;
        case (state)
            IDLE: if (start) begin
                state_n = SEND;
                cnt_n   = '0;
                // the direction bit goes out twice: once alone, then as the word MSB
                sh_n    = {tx_data[9], tx_data};
                rd_n    = &tx_data[9:8];
            end
            SEND: begin
                sh_n    = {sh[9:0], 1'b0};
                state_n = (cnt == CW'(10)) ? (rd ? TURN : END) : SEND;
                cnt_n   = (cnt == CW'(10)) ? '0 : cnt + 1'b1;
            end
            TURN: begin
                state_n = (cnt == CW'(TURNAROUND - 1)) ? RECV : TURN;
                cnt_n   = (cnt == CW'(TURNAROUND - 1)) ? '0 : cnt + 1'b1;
            end
            RECV: begin
                rx_sh_n   = {rx_sh[RX_W-2:0], MISO};
                state_n   = (cnt == CW'(RX_W - 1)) ? END : RECV;
                cnt_n     = (cnt == CW'(RX_W - 1)) ? '0 : cnt + 1'b1;
                rx_data_n = (cnt == CW'(RX_W - 1)) ? rx_sh_n : rx_data;
            end
            END:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            sh       <= '0;
            rd       <= 1'b0;
            rx_sh    <= '0;
            rx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_valid <= 1'b0;
            SS_n     <= 1'b1;
            MOSI     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            sh       <= sh_n;
            rd       <= rd_n;
            rx_sh    <= rx_sh_n;
            rx_data  <= rx_data_n;
            busy     <= state_n != IDLE;
            done     <= state_n == END;
            rx_valid <= (state_n == END) && rd_n;
            SS_n     <= !(state_n == SEND || state_n == TURN || state_n == RECV);
            MOSI     <= (state_n == SEND) && sh_n[10];
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: scoreboard bench for spi_master at TURNAROUND 2, 1 and 7.
module tb_spi_master;
    typedef struct {
        int          inst;
        int          len;
        logic [10:0] mosi;
        logic        rd;
        logic [7:0]  rx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start [3];
    logic [9:0] tx [3];
    logic       miso [3];
    logic       busy [3];
    logic       done [3];
    logic       rx_valid [3];
    logic       ss_n [3];
    logic       mosi [3];
    logic [7:0] rx_data [3];

    int   checks = 0;
    int   failures = 0;
    int   ndone [3];
    exp_t exp_q [$];
    int   gaps [$];

    always #5 clk = ~clk;

    spi_master #(.TURNAROUND(2), .RX_W(8)) u0 (.clk(clk), .rst_n(rst_n), .start(start[0]), .tx_data(tx[0]),
        .busy(busy[0]), .done(done[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
        .SS_n(ss_n[0]), .MOSI(mosi[0]), .MISO(miso[0]));
    spi_master #(.TURNAROUND(1), .RX_W(8)) u1 (.clk(clk), .rst_n(rst_n), .start(start[1]), .tx_data(tx[1]),
        .busy(busy[1]), .done(done[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
        .SS_n(ss_n[1]), .MOSI(mosi[1]), .MISO(miso[1]));
    spi_master #(.TURNAROUND(7), .RX_W(8)) u2 (.clk(clk), .rst_n(rst_n), .start(start[2]), .tx_data(tx[2]),
        .busy(busy[2]), .done(done[2]), .rx_data(rx_data[2]), .rx_valid(rx_valid[2]),
        .SS_n(ss_n[2]), .MOSI(mosi[2]), .MISO(miso[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : mon
        int          len = 0;
        int          hi = 0;
        logic [10:0] mb = '0;
        exp_t        e;
        always @(negedge clk) begin
            if (!rst_n) begin
                len = 0;
                hi  = 0;
            end else if (!ss_n[g]) begin
                if (hi > 0 && g == 0) gaps.push_back(hi);
                hi = 0;
                if (len < 11) mb = {mb[9:0], mosi[g]};
                len++;
            end else begin
                hi++;
                if (done[g]) begin
                    ndone[g]++;
                    check("mosi_end", {31'd0, mosi[g]}, 0);
                    if (exp_q.size() == 0) check("unexpected_done", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("inst", g, e.inst);
                        check("ss_len", len, e.len);
                        check("mosi_seq", {21'd0, mb}, {21'd0, e.mosi});
                        check("rx_valid", {31'd0, rx_valid[g]}, {31'd0, e.rd});
                        if (e.rd) check("rx_data", {24'd0, rx_data[g]}, {24'd0, e.rx});
                    end
                    len = 0;
                end
            end
        end
    end

    function automatic int tt_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 7;
    endfunction

    task automatic push_exp(input int i, input logic [9:0] t, input logic [7:0] rb);
        exp_t e;
        e.inst = i;
        e.rd   = (t[9:8] == 2'b11);
        e.len  = 11 + (e.rd ? tt_of(i) + 8 : 0);
        e.mosi = {t[9], t};
        e.rx   = rb;
        exp_q.push_back(e);
    endtask

    task automatic run_frame(input int i, input logic [9:0] t, input logic [7:0] rb);
        int tt = tt_of(i);
        logic rdf = (t[9:8] == 2'b11);
        int flen = 11 + (rdf ? tt + 8 : 0);
        int d0 = ndone[i];
        push_exp(i, t, rb);
        @(negedge clk);
        start[i] = 1'b1;
        tx[i] = t;
        @(posedge clk);
        #1;
        start[i] = 1'b0;
        tx[i] = 10'($urandom);
        check("busy_after_accept", {31'd0, busy[i]}, 1);
        for (int c = 1; c <= flen + 1; c++) begin
            miso[i] = (rdf && c >= 12 + tt && c <= 19 + tt) ? rb[7 - (c - 12 - tt)] : 1'($urandom);
            @(posedge clk);
            #1;
        end
        check("done_count", ndone[i] - d0, 1);
        check("busy_idle", {31'd0, busy[i]}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int d0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            tx[i] = '0;
            miso[i] = 1'b0;
            ndone[i] = 0;
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            check("rst_ss", {31'd0, ss_n[i]}, 1);
            check("rst_mosi", {31'd0, mosi[i]}, 0);
            check("rst_busy", {31'd0, busy[i]}, 0);
            check("rst_done", {31'd0, done[i]}, 0);
            check("rst_rx", {24'd0, rx_data[i]}, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_ss", {31'd0, ss_n[0]}, 1);
        check("rel_busy", {31'd0, busy[0]}, 0);
        check("rel_valid", {31'd0, rx_valid[0]}, 0);

        run_frame(0, 10'b00_1010_0101, 8'h00);
        run_frame(0, 10'b11_0000_0000, 8'hB3);
        run_frame(0, 10'b10_0110_1100, 8'h00);
        check("rx_hold", {24'd0, rx_data[0]}, 32'hB3);
        run_frame(0, 10'b01_1111_0000, 8'h00);
        run_frame(0, 10'b11_0101_1010, 8'h4C);

        gaps.delete();
        d0 = ndone[0];
        for (int k = 0; k < 3; k++) push_exp(0, 10'b01_1100_0011, 8'h00);
        @(negedge clk);
        start[0] = 1'b1;
        tx[0] = 10'b01_1100_0011;
        repeat (27) @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        check("b2b_dones", ndone[0] - d0, 3);
        check("b2b_gap_count", gaps.size(), 3);
        if (gaps.size() == 3) begin
            check("b2b_gap1", gaps[1], 2);
            check("b2b_gap2", gaps[2], 2);
        end

        d0 = ndone[0];
        push_exp(0, 10'b00_1111_1111, 8'h00);
        @(negedge clk);
        start[0] = 1'b1;
        tx[0] = 10'b00_1111_1111;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_ss", {31'd0, ss_n[0]}, 1);
        check("abort_mosi", {31'd0, mosi[0]}, 0);
        check("abort_busy", {31'd0, busy[0]}, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", ndone[0] - d0, 0);
        run_frame(0, 10'b00_0011_1100, 8'h00);

        run_frame(1, 10'b11_0000_0001, 8'hA5);
        run_frame(1, 10'b11_1000_0000, 8'($urandom));
        run_frame(2, 10'b11_0000_0010, 8'h3C);
        run_frame(2, 10'b00_1010_1010, 8'h00);
        run_frame(2, 10'b11_0000_0011, 8'($urandom));

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
